// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports, N combinational read ports,
// optional zero register and write-to-read bypass, per-register load busy scoreboard.
module register_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] ReadAddr,
   output logic [NUM_RD*DATA_W-1:0] ReadData,
   output logic [NUM_RD-1:0]        ReadBusy,
   input  logic                     WriteEnable0,
   input  logic [ADDR_W-1:0]        WriteAddr0,
   input  logic [DATA_W-1:0]        WriteData0,
   input  logic                     WriteEnable1,
   input  logic [ADDR_W-1:0]        WriteAddr1,
   input  logic [DATA_W-1:0]        WriteData1,
   input  logic                     Reserve,
   input  logic [ADDR_W-1:0]        ReserveAddr,
   output logic                     WriteConflict
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wrHit0;
   logic              wrHit1;
   logic              rsvHit;
   logic              conflictNext;
   logic [ADDR_W-1:0] rdAddr;

   // Gating with rst_n keeps a pending write from being forwarded while reset is held.
   assign wrHit0 = rst_n && WriteEnable0 && !((ZERO_REG != 0) && (WriteAddr0 == '0));
   assign wrHit1 = rst_n && WriteEnable1 && !((ZERO_REG != 0) && (WriteAddr1 == '0));
   assign rsvHit = Reserve && !((ZERO_REG != 0) && (ReserveAddr == '0));

   assign conflictNext = WriteEnable0 && WriteEnable1 && (WriteAddr0 == WriteAddr1) &&
                         !((ZERO_REG != 0) && (WriteAddr0 == '0));

   // Port 1 is assigned last so a load wins a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         if (wrHit0) regs[WriteAddr0] <= WriteData0;
         if (wrHit1) regs[WriteAddr1] <= WriteData1;
      end
   end

   // Reserve is applied after the clear so a newly issued load keeps the register busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy          <= '0;
         WriteConflict <= 1'b0;
      end else begin
         if (WriteEnable1) busy[WriteAddr1] <= 1'b0;
         if (rsvHit)       busy[ReserveAddr] <= 1'b1;
         WriteConflict <= conflictNext;
      end
   end

   always_comb begin
      ReadData = '0;
      ReadBusy = '0;
      rdAddr   = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rdAddr = ReadAddr[k*ADDR_W +: ADDR_W];
         ReadData[k*DATA_W +: DATA_W] = regs[rdAddr];
         ReadBusy[k] = busy[rdAddr];
         if (BYPASS != 0) begin
            if (wrHit0 && (WriteAddr0 == rdAddr)) ReadData[k*DATA_W +: DATA_W] = WriteData0;
            if (wrHit1 && (WriteAddr1 == rdAddr)) ReadData[k*DATA_W +: DATA_W] = WriteData1;
            if (rst_n && WriteEnable1 && (WriteAddr1 == rdAddr)) ReadBusy[k] = 1'b0;
         end
         if ((ZERO_REG != 0) && (rdAddr == '0)) ReadData[k*DATA_W +: DATA_W] = '0;
      end
   end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port register file for the Mini-MIPS datapath; successor to the single-write, two-read 32x32 file.
- Adds the following:
  - configurable width, depth and read-port count;
  - a second write port for load write-back;
  - asynchronous clear;
  - optional hardwired zero register;
  - optional write-to-read bypass;
  - per-register busy scoreboard for outstanding loads.
- Sits between decode (reads) and the ALU/memory write-back stages.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reserves.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ReadAddr  in  NUM_RD*ADDR_W  read addresses; port k in bits [k*ADDR_W +: ADDR_W].
- ReadData  out  NUM_RD*DATA_W  read data, port k in bits [k*DATA_W +: DATA_W]; combinational.
- ReadBusy  out  NUM_RD  bit k = addressed register has a pending load; combinational.
- WriteEnable0  in  1  ALU write-back enable.
- WriteAddr0  in  ADDR_W  ALU write-back address.
- WriteData0  in  DATA_W  ALU write-back data.
- WriteEnable1  in  1  load write-back enable.
- WriteAddr1  in  ADDR_W  load write-back address.
- WriteData1  in  DATA_W  load write-back data.
- Reserve  in  1  mark ReserveAddr busy (load issued).
- ReserveAddr  in  ADDR_W  register to reserve.
- WriteConflict  out  1  registered pulse: both write ports hit the same register in the previous cycle.

Behaviour:
- Reset (rst_n low, async, no clock required):
  - all DEPTH registers go to 0;
  - all busy bits go to 0;
  - WriteConflict goes to 0.
  - While reset is held, writes and reserves are ignored.
  - Release is synchronised by the user; the first active edge after release may write.
- Writes: registered on the rising clk edge.
  - Each enabled port updates its addressed register.
  - Same address on both ports: port 1 (load) wins; port 0 data is discarded.
  - Different addresses: both are written in the same edge.
  - When ZERO_REG=1, writes to address 0 are dropped and RF[0] stays 0.
- Reads: combinational, with zero clock latency.
  - ZERO_REG=1 and address 0: returns 0 regardless of bypass.
  - BYPASS=1 and the address matches an enabled write this cycle: returns that write data. Port 1 has priority if both ports match.
  - Otherwise returns the stored value.
  - BYPASS=0: returns the stored value only; the new value is visible the cycle after the write edge.
- Scoreboard: one busy bit per register, updated on the clock edge.
  - Reserve=1 sets busy[ReserveAddr].
  - WriteEnable1=1 clears busy[WriteAddr1].
  - Port 0 writes do not affect busy.
  - Set and clear on the same address in the same cycle: set wins, because a new load was issued.
  - Reserve on an already-busy register keeps it busy, with no count kept.
  - ZERO_REG=1: reserve of address 0 is ignored and busy[0] stays 0.
- ReadBusy[k]:
  - equals busy[ReadAddr_k];
  - with BYPASS=1, it is forced to 0 when WriteEnable1 targets the same address this cycle, because the data is forwarded.
- WriteConflict is registered. It is 1 for exactly one cycle after an edge where all of the following hold:
  - both write enables are high;
  - WriteAddr0 == WriteAddr1;
  - the address is nonzero, or ZERO_REG=0.
  - Otherwise WriteConflict is 0.
- Reset asserted mid-operation: the pending edge's writes are lost, and all state is cleared immediately.
- Address width rules: all addresses are fully decoded, with no wrap or out-of-range case because DEPTH = 2**ADDR_W.

Test Plan:
- Reset then sweep: rst_n=0 → all ReadData=0, ReadBusy=0, WriteConflict=0. Release, then write RF[i]=i*3 via port 0 for i=1..31 → readback gives i*3 on both read ports.
- Zero register: write 0xDEADBEEF to address 0 on both ports, and Reserve addr 0 → ReadData for address 0 = 0, ReadBusy=0, WriteConflict stays 0.
- Dual-write collision: port 0 writes 5 ← 0x11 and port 1 writes 5 ← 0x22 in the same cycle → RF[5]=0x22 next cycle; WriteConflict=1 for exactly one cycle, then 0.
- Bypass: BYPASS=1, RF[7]=1. Write 7 ← 0x99 while ReadAddr0=7 → ReadData0=0x99 in the same cycle. Rebuild with BYPASS=0 → ReadData0=1 that cycle and 0x99 the next cycle.
- Scoreboard:
  - Reserve 9 → ReadBusy=1 next cycle.
  - In one cycle: port 1 writes 9 and Reserve 9 → register updated, busy stays 1.
  - Later port 1 write to 9 alone → ReadBusy=0 in that cycle (bypass) and busy=0 afterwards.
  - A port 0 write to 9 while busy → busy unchanged.
- Async reset mid-stream: drive rst_n low between clock edges with writes pending to register 12 and busy[12]=1 → ReadData=0 and ReadBusy=0 immediately, with no edge required.
